// File: rtl/rd_wb_scoreboard_if.sv
// Issue/writeback bundle for rd_wb_scoreboard. With SB_FWD_EN defined it also
// carries the forwarding hit flags.
interface rd_wb_scoreboard_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_wr;
  logic [AW-1:0] issue_rs;
  logic [AW-1:0] issue_rt;
  logic          issue_use_rs;
  logic          issue_use_rt;
  logic          issue_ready;

  logic          wb0_valid;
  logic [AW-1:0] wb0_rd;
  logic [DW-1:0] wb0_data;

  logic          wb1_valid;
  logic [AW-1:0] wb1_rd;
  logic [DW-1:0] wb1_data;
  logic          wb1_ready;

  logic          pipe_stall;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef SB_FWD_EN
  logic          fwd_rs_hit;
  logic          fwd_rt_hit;
`endif

  modport slave (
    input  issue_valid, issue_rd, issue_wr, issue_rs, issue_rt,
    input  issue_use_rs, issue_use_rt,
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    output issue_ready, wb1_ready, pipe_stall,
`ifdef SB_FWD_EN
    output fwd_rs_hit, fwd_rt_hit,
`endif
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output issue_valid, issue_rd, issue_wr, issue_rs, issue_rt,
    output issue_use_rs, issue_use_rt,
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    input  issue_ready, wb1_ready, pipe_stall,
`ifdef SB_FWD_EN
    input  fwd_rs_hit, fwd_rt_hit,
`endif
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rd_wb_scoreboard.sv
// Pending-write scoreboard with RAW/WAW issue stall and two-source regfile
// write arbitration. Define SB_FWD_EN to waive source hazards on the rf write.
module rd_wb_scoreboard #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  rd_wb_scoreboard_if.slave sb
);
  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX - 1);

  logic [NREG-1:0] busy_reg, busy_next;
  logic            hold_valid_reg, hold_valid_next;
  logic [AW-1:0]   hold_rd_reg, hold_rd_next;
  logic [DW-1:0]   hold_data_reg, hold_data_next;
  logic [CW-1:0]   starve_reg, starve_next;
  logic            pipe_stall_reg, pipe_stall_next;
  logic            rf_we_reg;
  logic [AW-1:0]   rf_waddr_reg;
  logic [DW-1:0]   rf_wdata_reg;

  logic            commit_valid;
  logic [AW-1:0]   commit_rd;
  logic [DW-1:0]   commit_data;
  logic            haz_rs, haz_rt, haz_waw;
  logic            issue_fire;

  // Source hazards; with forwarding, a source matching the write in flight
  // this cycle is satisfied from rf_wdata instead of stalling.
`ifdef SB_FWD_EN
  logic fwd_rs, fwd_rt;
  assign fwd_rs = rf_we_reg && (rf_waddr_reg == sb.issue_rs) && (sb.issue_rs != '0);
  assign fwd_rt = rf_we_reg && (rf_waddr_reg == sb.issue_rt) && (sb.issue_rt != '0);
  assign haz_rs = sb.issue_use_rs && busy_reg[sb.issue_rs] && !fwd_rs;
  assign haz_rt = sb.issue_use_rt && busy_reg[sb.issue_rt] && !fwd_rt;
  assign sb.fwd_rs_hit = sb.issue_use_rs && fwd_rs;
  assign sb.fwd_rt_hit = sb.issue_use_rt && fwd_rt;
`else
  assign haz_rs = sb.issue_use_rs && busy_reg[sb.issue_rs];
  assign haz_rt = sb.issue_use_rt && busy_reg[sb.issue_rt];
`endif
  assign haz_waw = sb.issue_wr && busy_reg[sb.issue_rd];

  assign sb.issue_ready = !haz_rs && !haz_rt && !haz_waw;
  assign issue_fire     = sb.issue_valid && sb.issue_ready && sb.issue_wr &&
                          (sb.issue_rd != '0);

  // Busy bits: a new issue on a register wins over a same-cycle retire.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_reg
      logic set_bit, clr_bit;
      assign set_bit = issue_fire && (sb.issue_rd == AW'(gi));
      assign clr_bit = rf_we_reg && (rf_waddr_reg == AW'(gi));
      assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
    end
  end

  assign sb.wb1_ready = !hold_valid_reg;

  // Write-port grant: main pipe first, then the held long-unit entry,
  // then a direct long-unit write.
  always_comb begin
    commit_valid    = 1'b0;
    commit_rd       = hold_rd_reg;
    commit_data     = hold_data_reg;
    hold_valid_next = hold_valid_reg;
    hold_rd_next    = hold_rd_reg;
    hold_data_next  = hold_data_reg;
    if (sb.wb0_valid) begin
      commit_valid = 1'b1;
      commit_rd    = sb.wb0_rd;
      commit_data  = sb.wb0_data;
      if (sb.wb1_valid && !hold_valid_reg) begin
        hold_valid_next = 1'b1;
        hold_rd_next    = sb.wb1_rd;
        hold_data_next  = sb.wb1_data;
      end
    end else if (hold_valid_reg) begin
      commit_valid    = 1'b1;
      hold_valid_next = 1'b0;
    end else if (sb.wb1_valid) begin
      commit_valid = 1'b1;
      commit_rd    = sb.wb1_rd;
      commit_data  = sb.wb1_data;
    end
  end

  // Starvation: count cycles the held entry loses to wb0, saturating at the
  // limit; the pipe is frozen once the limit is reached with hold still full.
  always_comb begin
    starve_next = '0;
    if (hold_valid_next) begin
      starve_next = starve_reg;
      if (hold_valid_reg && sb.wb0_valid && (starve_reg < STARVE_LIM))
        starve_next = starve_reg + CW'(1);
    end
    pipe_stall_next = hold_valid_next && (starve_next >= STARVE_LIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_reg       <= '0;
      hold_valid_reg <= 1'b0;
      hold_rd_reg    <= '0;
      hold_data_reg  <= '0;
      starve_reg     <= '0;
      pipe_stall_reg <= 1'b0;
      rf_we_reg      <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
    end else begin
      busy_reg       <= busy_next;
      hold_valid_reg <= hold_valid_next;
      hold_rd_reg    <= hold_rd_next;
      hold_data_reg  <= hold_data_next;
      starve_reg     <= starve_next;
      pipe_stall_reg <= pipe_stall_next;
      // A commit to r0 is consumed but never reaches the regfile.
      rf_we_reg      <= commit_valid && (commit_rd != '0);
      if (commit_valid) begin
        rf_waddr_reg <= commit_rd;
        rf_wdata_reg <= commit_data;
      end
    end
  end

  assign sb.pipe_stall = pipe_stall_reg;
  assign sb.rf_we      = rf_we_reg;
  assign sb.rf_waddr   = rf_waddr_reg;
  assign sb.rf_wdata   = rf_wdata_reg;
endmodule

// File: tb/tb_rd_wb_scoreboard.sv
// Directed bench for rd_wb_scoreboard; expectations follow SB_FWD_EN when set.
module tb_rd_wb_scoreboard;
  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  rd_wb_scoreboard_if #(.AW(5), .DW(32)) bus ();

  rd_wb_scoreboard #(.NREG(32), .AW(5), .DW(32), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic wr,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt);
    bus.issue_valid  = v;
    bus.issue_rd     = rd;
    bus.issue_wr     = wr;
    bus.issue_rs     = rs;
    bus.issue_use_rs = urs;
    bus.issue_rt     = rt;
    bus.issue_use_rt = urt;
  endtask

  task automatic wb0(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.wb0_valid = v;
    bus.wb0_rd    = rd;
    bus.wb0_data  = d;
  endtask

  task automatic wb1(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.wb1_valid = v;
    bus.wb1_rd    = rd;
    bus.wb1_data  = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // The main pipe must never present a writeback while frozen.
  always @(negedge clock) begin
    if (!reset) begin
      assert (!(bus.pipe_stall && bus.wb0_valid)) else begin
        failures++;
        $error("FAIL wb0_during_stall observed=1 expected=0");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0);
    wb0(0, 0, 0);
    wb1(0, 0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    issue(0, 5, 1, 5, 1, 0, 0);
    @(negedge clock);
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_pipe_stall", 32'(bus.pipe_stall), 0);
    chk("rst_wb1_ready", 32'(bus.wb1_ready), 1);
    chk("rst_issue_ready", 32'(bus.issue_ready), 1);
    next_cycle();

    // Reset mid-operation: busy[5] set and a wb1 entry held
    issue(1, 5, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("t1_issue5_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0);
    wb0(1, 1, 32'h11);
    wb1(1, 2, 32'h22);
    @(negedge clock);
    chk("t1_capture_ready", 32'(bus.wb1_ready), 1);
    next_cycle();
    wb0(0, 0, 0);
    wb1(0, 0, 0);
    issue(0, 5, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("t1_waw5_stall", 32'(bus.issue_ready), 0);
    chk("t1_hold_full", 32'(bus.wb1_ready), 0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("t1_post_rf_we", 32'(bus.rf_we), 0);
    chk("t1_post_stall", 32'(bus.pipe_stall), 0);
    chk("t1_post_wb1_ready", 32'(bus.wb1_ready), 1);
    chk("t1_post_busy5", 32'(bus.issue_ready), 1);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("t1_hold_empty_we", 32'(bus.rf_we), 0);
    next_cycle();

    // RAW on rd=8 through wb0
    issue(1, 8, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("t2_issue8_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    issue(1, 0, 0, 8, 1, 0, 0);
    wb0(1, 8, 32'hDEADBEEF);
    @(negedge clock);
    chk("t2_raw_N", 32'(bus.issue_ready), 0);
    next_cycle();
    wb0(0, 0, 0);
    @(negedge clock);
    chk("t2_rf_we", 32'(bus.rf_we), 1);
    chk("t2_rf_waddr", 32'(bus.rf_waddr), 8);
    chk("t2_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
`ifdef SB_FWD_EN
    chk("t2_raw_N1_fwd", 32'(bus.issue_ready), 1);
    chk("t2_fwd_rs_hit", 32'(bus.fwd_rs_hit), 1);
`else
    chk("t2_raw_N1", 32'(bus.issue_ready), 0);
`endif
    next_cycle();
    @(negedge clock);
    chk("t2_raw_N2", 32'(bus.issue_ready), 1);
    chk("t2_rf_we_off", 32'(bus.rf_we), 0);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0);

    // wb0 and wb1 together: wb1 captured, committed next
    wb0(1, 3, 32'h33);
    wb1(1, 4, 32'h44);
    @(negedge clock);
    chk("t3_wb1_ready", 32'(bus.wb1_ready), 1);
    next_cycle();
    wb0(0, 0, 0);
    wb1(0, 0, 0);
    @(negedge clock);
    chk("t3_we_a", 32'(bus.rf_we), 1);
    chk("t3_waddr_a", 32'(bus.rf_waddr), 3);
    chk("t3_wdata_a", bus.rf_wdata, 32'h33);
    chk("t3_hold_busy", 32'(bus.wb1_ready), 0);
    next_cycle();
    @(negedge clock);
    chk("t3_we_b", 32'(bus.rf_we), 1);
    chk("t3_waddr_b", 32'(bus.rf_waddr), 4);
    chk("t3_wdata_b", bus.rf_wdata, 32'h44);
    chk("t3_hold_free", 32'(bus.wb1_ready), 1);
    next_cycle();
    @(negedge clock);
    chk("t3_we_idle", 32'(bus.rf_we), 0);
    next_cycle();

    // Starvation: held entry loses to wb0 until the pipe is frozen
    wb0(1, 10, 32'hA0);
    wb1(1, 11, 32'hB1);
    @(negedge clock);
    chk("t4_c0_wb1_ready", 32'(bus.wb1_ready), 1);
    chk("t4_c0_stall", 32'(bus.pipe_stall), 0);
    next_cycle();
    wb1(0, 0, 0);
    wb0(1, 12, 32'hC2);
    @(negedge clock);
    chk("t4_c1_stall", 32'(bus.pipe_stall), 0);
    chk("t4_c1_waddr", 32'(bus.rf_waddr), 10);
    chk("t4_c1_wb1_ready", 32'(bus.wb1_ready), 0);
    next_cycle();
    wb0(1, 13, 32'hC3);
    @(negedge clock);
    chk("t4_c2_stall", 32'(bus.pipe_stall), 0);
    next_cycle();
    wb0(1, 14, 32'hC4);
    @(negedge clock);
    chk("t4_c3_stall", 32'(bus.pipe_stall), 0);
    next_cycle();
    wb0(0, 0, 0);
    @(negedge clock);
    chk("t4_c4_stall", 32'(bus.pipe_stall), 1);
    chk("t4_c4_waddr", 32'(bus.rf_waddr), 14);
    chk("t4_c4_wb1_ready", 32'(bus.wb1_ready), 0);
    next_cycle();
    @(negedge clock);
    chk("t4_c5_stall", 32'(bus.pipe_stall), 0);
    chk("t4_c5_we", 32'(bus.rf_we), 1);
    chk("t4_c5_waddr", 32'(bus.rf_waddr), 11);
    chk("t4_c5_wdata", bus.rf_wdata, 32'hB1);
    chk("t4_c5_wb1_ready", 32'(bus.wb1_ready), 1);
    next_cycle();
    @(negedge clock);
    chk("t4_c6_we", 32'(bus.rf_we), 0);
    next_cycle();

    // Register 0: never busy, never written, entry still consumed
    issue(1, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("t5_issue0_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    wb1(1, 0, 32'h77);
    @(negedge clock);
    chk("t5_busy0_clear", 32'(bus.issue_ready), 1);
    chk("t5_wb1_ready", 32'(bus.wb1_ready), 1);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0);
    wb1(0, 0, 0);
    @(negedge clock);
    chk("t5_rf_we0", 32'(bus.rf_we), 0);
    chk("t5_consumed", 32'(bus.wb1_ready), 1);
    next_cycle();
    @(negedge clock);
    chk("t5_rf_we0_later", 32'(bus.rf_we), 0);
    next_cycle();

    // WAW on register 9, plus an rt RAW while it is busy
    issue(1, 9, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("t6_issue9_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    @(negedge clock);
    chk("t6_waw9", 32'(bus.issue_ready), 0);
    next_cycle();
    issue(1, 0, 0, 0, 0, 9, 1);
    wb1(1, 9, 32'h99);
    @(negedge clock);
    chk("t6_raw_rt9", 32'(bus.issue_ready), 0);
    chk("t6_wb1_ready", 32'(bus.wb1_ready), 1);
    next_cycle();
    issue(1, 9, 1, 0, 0, 0, 0);
    wb1(0, 0, 0);
    @(negedge clock);
    chk("t6_rf_we9", 32'(bus.rf_we), 1);
    chk("t6_rf_waddr9", 32'(bus.rf_waddr), 9);
    chk("t6_waw9_still", 32'(bus.issue_ready), 0);
    next_cycle();
    @(negedge clock);
    chk("t6_waw9_release", 32'(bus.issue_ready), 1);
    next_cycle();
    issue(0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
